peripheral_dma_scheduler: RTL and testbench

PERIPHERAL_DMA_SCHEDULER -- requirements
Module: peripheral_dma_scheduler

---
 rtl/peripheral_dma_scheduler_if.sv | 55 +++++
 rtl/peripheral_dma_scheduler.sv | 172 +++++++++++++++++
 tb/tb_peripheral_dma_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_dma_scheduler_if.sv
// Channel request, completion and connector signals of the DMA scheduler.
// master = scheduler side, slave = channels plus connector side.
interface peripheral_dma_scheduler_if;
  logic        ch0_req;
  logic        ch0_wren;
  logic [2:0]  ch0_peripheral_addr;
  logic [15:0] ch0_cache_addr;
  logic [15:0] ch0_count;
  logic        ch0_ack;
  logic        ch0_done;
  logic        ch1_req;
  logic        ch1_wren;
  logic [2:0]  ch1_peripheral_addr;
  logic [15:0] ch1_cache_addr;
  logic [15:0] ch1_count;
  logic        ch1_ack;
  logic        ch1_done;
  logic [15:0] done_count;
  logic        done_error;
  logic        busy;
  logic        start_operation;
  logic        new_wren;
  logic [2:0]  new_peripheral_addr;
  logic [15:0] new_cache_addr;
  logic [15:0] new_count;
  logic        is_running;
  logic [15:0] res_count;
  logic        abort;

  modport master (
    input  ch0_req, ch0_wren, ch0_peripheral_addr,
    input  ch0_cache_addr, ch0_count,
    input  ch1_req, ch1_wren, ch1_peripheral_addr,
    input  ch1_cache_addr, ch1_count,
    input  is_running, res_count,
    output ch0_ack, ch0_done, ch1_ack, ch1_done,
    output done_count, done_error, busy,
    output start_operation, abort,
    output new_wren, new_peripheral_addr,
    output new_cache_addr, new_count
  );

  modport slave (
    output ch0_req, ch0_wren, ch0_peripheral_addr,
    output ch0_cache_addr, ch0_count,
    output ch1_req, ch1_wren, ch1_peripheral_addr,
    output ch1_cache_addr, ch1_count,
    output is_running, res_count,
    input  ch0_ack, ch0_done, ch1_ack, ch1_done,
    input  done_count, done_error, busy,
    input  start_operation, abort,
    input  new_wren, new_peripheral_addr,
    input  new_cache_addr, new_count
  );
endinterface

// File: rtl/peripheral_dma_scheduler.sv
// Two-channel round-robin DMA scheduler driving one transfer connector.
// Define DMA_WATCHDOG_EN to abort transfers running past WATCHDOG_CYCLES.
module peripheral_dma_scheduler #(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input logic clock,
  input logic reset,
  peripheral_dma_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETTLE,
    RUN,
    DONE
  } state_e;

  if (WATCHDOG_CYCLES == 0) begin : g_cfg_err
    $error("WATCHDOG_CYCLES must be nonzero");
  end

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        wren_q, wren_d;
  logic [2:0]  periph_q, periph_d;
  logic [15:0] cache_q, cache_d;
  logic [15:0] count_q, count_d;
  logic [15:0] dcount_q, dcount_d;
  logic        ack0, ack1;
  logic        req_any;
  logic        pick;
  logic [15:0] pick_count;
  logic        wd_hit;

  assign req_any = (bus.ch0_req | bus.ch1_req) & ~reset;

  // On a tie the channel not granted last wins.
  always_comb begin
    if (bus.ch0_req && bus.ch1_req) begin
      pick = ~last_q;
    end else begin
      pick = bus.ch1_req;
    end
  end

  assign pick_count = pick ? bus.ch1_count : bus.ch0_count;

`ifdef DMA_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q;

  always_comb begin
    wd_d = '0;
    if (state_q == RUN) begin
      wd_d = wd_q;
      if (wd_q != WDW'(WATCHDOG_CYCLES)) begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  assign wd_hit = (state_q == RUN) && bus.is_running &&
                  (wd_q >= WDW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (state_q == RUN && state_d == DONE) begin
        err_q <= wd_hit;
      end else if (state_q == IDLE && state_d == DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.abort      = wd_hit;
  assign bus.done_error = err_q;
`else
  assign wd_hit         = 1'b0;
  assign bus.abort      = 1'b0;
  assign bus.done_error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wren_d   = wren_q;
    periph_d = periph_q;
    cache_d  = cache_q;
    count_d  = count_q;
    dcount_d = dcount_q;
    ack0     = 1'b0;
    ack1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = pick;
          last_d  = pick;
          ack0    = ~pick;
          ack1    = pick;
          count_d = pick_count;
          if (pick) begin
            wren_d   = bus.ch1_wren;
            periph_d = bus.ch1_peripheral_addr;
            cache_d  = bus.ch1_cache_addr;
          end else begin
            wren_d   = bus.ch0_wren;
            periph_d = bus.ch0_peripheral_addr;
            cache_d  = bus.ch0_cache_addr;
          end
          state_d = (pick_count == 16'd0) ? DONE : START;
        end
      end
      START:  state_d = SETTLE;
      SETTLE: state_d = RUN;
      RUN: begin
        if (!bus.is_running || wd_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dcount_d = (count_q == 16'd0) ? 16'd0 : bus.res_count;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      wren_q   <= 1'b0;
      periph_q <= '0;
      cache_q  <= '0;
      count_q  <= '0;
      dcount_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wren_q   <= wren_d;
      periph_q <= periph_d;
      cache_q  <= cache_d;
      count_q  <= count_d;
      dcount_q <= dcount_d;
    end
  end

  assign bus.ch0_ack  = ack0;
  assign bus.ch1_ack  = ack1;
  assign bus.ch0_done = (state_q == DONE) && !grant_q;
  assign bus.ch1_done = (state_q == DONE) && grant_q;
  assign bus.done_count =
    (state_q == DONE) ? dcount_d : dcount_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.start_operation = (state_q == START);
  assign bus.new_wren            = wren_q;
  assign bus.new_peripheral_addr = periph_q;
  assign bus.new_cache_addr      = cache_q;
  assign bus.new_count           = count_q;

endmodule

// File: tb/tb_peripheral_dma_scheduler.sv
// Directed bench for peripheral_dma_scheduler with a simple connector model.
// Both watchdog builds are covered through DMA_WATCHDOG_EN.
module tb_peripheral_dma_scheduler;
  localparam int WD = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  peripheral_dma_scheduler_if b();

  peripheral_dma_scheduler #(
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(b)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int n_ack0, n_ack1, n_done0, n_done1;
  int n_start, n_abort, n_bad;

  logic [15:0] rem = '0;
  logic        stuck = 1'b0;
  logic [15:0] res_xor = '0;

  // Connector: busy for new_count cycles after each start pulse.
  always @(posedge clock) begin
    if (b.start_operation) rem <= b.new_count;
    else if (rem != 0) rem <= rem - 16'd1;
  end

  assign b.is_running = stuck | (rem != 16'd0);
  assign b.res_count  = b.new_count ^ res_xor;

  always @(negedge clock) begin
    if (b.ch0_ack) n_ack0++;
    if (b.ch1_ack) n_ack1++;
    if (b.ch0_done) n_done0++;
    if (b.ch1_done) n_done1++;
    if (b.start_operation) n_start++;
    if (b.abort) n_abort++;
    if (b.ch0_ack && b.ch1_ack) n_bad++;
    if (b.ch0_done && b.ch1_done) n_bad++;
    if ((b.ch0_ack | b.ch1_ack) && (b.ch0_done | b.ch1_done)) n_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic drv();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0;
    n_start = 0; n_abort = 0; n_bad = 0;
  endtask

  task automatic wait_done(input int lim, output int ch);
    ch = -1;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (b.ch0_done) ch = 0;
      else if (b.ch1_done) ch = 1;
      if (ch >= 0) break;
    end
  endtask

  task automatic pulse_reset();
    drv();
    reset = 1'b1;
    drv();
    reset = 1'b0;
  endtask

  int ch;
  int t;

  initial begin
    b.ch0_req = 0; b.ch0_wren = 0; b.ch0_peripheral_addr = 0;
    b.ch0_cache_addr = 0; b.ch0_count = 0;
    b.ch1_req = 0; b.ch1_wren = 0; b.ch1_peripheral_addr = 0;
    b.ch1_cache_addr = 0; b.ch1_count = 0;
    clr();

    repeat (2) drv();
    cyc();
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_ack", 32'({b.ch0_ack, b.ch1_ack}), 0);
    chk("rst_dcnt", 32'(b.done_count), 0);
    chk("rst_ncnt", 32'(b.new_count), 0);
    chk("rst_start", 32'(b.start_operation), 0);
    chk("rst_abort", 32'(b.abort), 0);
    chk("rst_err", 32'(b.done_error), 0);

    // Single ch0 transfer
    drv();
    reset = 1'b0;
    clr();
    b.ch0_count = 16'd8; b.ch0_wren = 1'b1;
    b.ch0_peripheral_addr = 3'd3; b.ch0_cache_addr = 16'h0100;
    b.ch0_req = 1'b1;
    cyc();
    chk("t1_ack0", 32'(b.ch0_ack), 1);
    chk("t1_ack1", 32'(b.ch1_ack), 0);
    drv();
    b.ch0_req = 1'b0;
    cyc();
    chk("t1_start", 32'(b.start_operation), 1);
    chk("t1_busy", 32'(b.busy), 1);
    chk("t1_wren", 32'(b.new_wren), 1);
    chk("t1_periph", 32'(b.new_peripheral_addr), 3);
    chk("t1_cache", 32'(b.new_cache_addr), 32'h0100);
    chk("t1_count", 32'(b.new_count), 8);
    wait_done(40, ch);
    chk("t1_done_ch", 32'(ch), 0);
    chk("t1_dcnt", 32'(b.done_count), 8);
    chk("t1_err", 32'(b.done_error), 0);
    cyc();
    chk("t1_hold", 32'(b.done_count), 8);
    chk("t1_idle", 32'(b.busy), 0);
    chk("t1_nstart", 32'(n_start), 1);
    chk("t1_ndone", 32'(n_done0), 1);
    chk("t1_nack", 32'(n_ack0), 1);

    // Round robin, both requesting straight out of reset
    drv();
    reset = 1'b1;
    drv();
    reset = 1'b0;
    clr();
    b.ch0_count = 16'd3; b.ch0_wren = 1'b0;
    b.ch0_peripheral_addr = 3'd1; b.ch0_cache_addr = 16'h0200;
    b.ch1_count = 16'd5; b.ch1_wren = 1'b1;
    b.ch1_peripheral_addr = 3'd6; b.ch1_cache_addr = 16'h0300;
    b.ch0_req = 1'b1;
    b.ch1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, ch);
      chk("rr_ch", 32'(ch), 32'(k % 2));
      chk("rr_dcnt", 32'(b.done_count), (k % 2) ? 5 : 3);
      chk("rr_cache", 32'(b.new_cache_addr),
          (k % 2) ? 32'h0300 : 32'h0200);
    end
    drv();
    b.ch0_req = 1'b0;
    b.ch1_req = 1'b0;
    cyc();
    chk("rr_ack0", 32'(n_ack0), 2);
    chk("rr_ack1", 32'(n_ack1), 2);
    chk("rr_done0", 32'(n_done0), 2);
    chk("rr_done1", 32'(n_done1), 2);
    chk("rr_overlap", 32'(n_bad), 0);

    // Zero-count transfer on ch1
    clr();
    res_xor = 16'h00AA;
    drv();
    b.ch1_count = 16'd0;
    b.ch1_req = 1'b1;
    cyc();
    chk("z_ack1", 32'(b.ch1_ack), 1);
    drv();
    b.ch1_req = 1'b0;
    cyc();
    chk("z_done1", 32'(b.ch1_done), 1);
    chk("z_dcnt", 32'(b.done_count), 0);
    chk("z_start", 32'(b.start_operation), 0);
    cyc();
    chk("z_idle", 32'(b.busy), 0);
    chk("z_nstart", 32'(n_start), 0);
    chk("z_ndone", 32'(n_done1), 1);
    res_xor = 16'h0000;

    // Reset in the middle of RUN, request kept high
    clr();
    drv();
    b.ch0_count = 16'd20;
    b.ch0_req = 1'b1;
    cyc();
    chk("r_ack", 32'(b.ch0_ack), 1);
    repeat (5) cyc();
    chk("r_busy_run", 32'(b.busy), 1);
    pulse_reset();
    cyc();
    chk("r_idle", 32'(b.busy), 0);
    chk("r_nodone", 32'(n_done0), 0);
    chk("r_reack", 32'(b.ch0_ack), 1);
    drv();
    b.ch0_req = 1'b0;
    wait_done(60, ch);
    chk("r_done_ch", 32'(ch), 0);
    chk("r_dcnt", 32'(b.done_count), 20);
    cyc();
    chk("r_ndone", 32'(n_done0), 1);

    // Connector stuck busy
    clr();
    stuck = 1'b1;
    drv();
    b.ch1_count = 16'd4;
    b.ch1_req = 1'b1;
    cyc();
    chk("w_ack", 32'(b.ch1_ack), 1);
    drv();
    b.ch1_req = 1'b0;
`ifdef DMA_WATCHDOG_EN
    t = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      t++;
      if (b.abort) break;
    end
    chk("w_abort_at", 32'(t), 18);
    chk("w_abort", 32'(b.abort), 1);
    chk("w_nodone", 32'(b.ch1_done), 0);
    cyc();
    chk("w_done", 32'(b.ch1_done), 1);
    chk("w_err", 32'(b.done_error), 1);
    chk("w_nabort", 32'(n_abort), 1);
    cyc();
    chk("w_idle", 32'(b.busy), 0);
`else
    repeat (60) cyc();
    chk("w_busy", 32'(b.busy), 1);
    chk("w_nabort", 32'(n_abort), 0);
    chk("w_err", 32'(b.done_error), 0);
    chk("w_ndone", 32'(n_done1), 0);
`endif
    stuck = 1'b0;
    pulse_reset();
    cyc();
    chk("w_reset", 32'(b.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
